// File: rtl/aes_key_schedule_iter_if.sv
`default_nettype none
// ============================================================================
//  Module      : aes_key_schedule_iter_if
//  Description : Control and round-key read bundle of the iterative AES key
//                expander.
//                master : the cipher/controller side. It drives start,
//                         key_len, key_in and rd_idx.
//                slave  : the expander. It drives busy, done, rk_valid,
//                         num_rounds, err and rd_key.
//                Signals:
//                  start      1   request a new expansion (sampled when idle)
//                  key_len    2   0=AES-128, 1=AES-192, 2=AES-256, 3=reserved
//                  key_in     256 cipher key, MSB-aligned
//                  busy       1   expansion in progress
//                  done       1   one-cycle pulse on the final schedule write
//                  rk_valid   1   word file holds a complete schedule
//                  num_rounds 4   Nr of the latched configuration
//                  err        1   one-cycle pulse on a reserved key_len start
//                  rd_idx     4   round-key index 0..Nr
//                  rd_key     128 registered round key for rd_idx
//  Revision    : 1.0 - initial release
// ============================================================================
interface aes_key_schedule_iter_if;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key_in;
    logic         busy;
    logic         done;
    logic         rk_valid;
    logic [3:0]   num_rounds;
    logic         err;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;

    modport master (
        output start, key_len, key_in, rd_idx,
        input  busy, done, rk_valid, num_rounds, err, rd_key
    );

    modport slave (
        input  start, key_len, key_in, rd_idx,
        output busy, done, rk_valid, num_rounds, err, rd_key
    );
endinterface
`default_nettype wire

// File: rtl/aes_key_schedule_iter.sv
`default_nettype none
// ============================================================================
//  Module      : aes_key_schedule_iter
//  Description : Iterative AES-128/192/256 key expander. A start loads the key
//                words into a 60-word schedule file. WORDS_PER_CYCLE new words
//                (1, 2 or 4) are then generated per clock until the schedule
//                of 4*(Nr+1) words is complete. A registered read port returns
//                the 128-bit round key selected by rd_idx.
//  Ports       : clk    rising-edge clock
//                rst_n  asynchronous active-low reset
//                bus    aes_key_schedule_iter_if.slave
//                       (start/key_len/key_in in; busy/done/rk_valid/
//                       num_rounds/err out; rd_idx in, rd_key out)
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_key_schedule_iter #(
    parameter int WORDS_PER_CYCLE = 1
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    aes_key_schedule_iter_if.slave bus
);

    localparam int         c_WPC      = WORDS_PER_CYCLE;
    localparam logic [0:0] c_S_IDLE   = 1'b0;
    localparam logic [0:0] c_S_EXPAND = 1'b1;

    // ------------------------------------------------------------------
    // GF(2^8) helpers. The S-box is built from the multiplicative inverse
    // (x^254) followed by the AES affine transform. This avoids a 256-entry
    // table per S-box instance.
    // ------------------------------------------------------------------
    function automatic logic [7:0] f_xtime(input logic [7:0] a);
        return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] f_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = f_xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] f_sbox(input logic [7:0] a);
        logic [7:0] a2, a4, a8, a16, a32, a64, a128, inv;
        a2   = f_gmul(a,   a);
        a4   = f_gmul(a2,  a2);
        a8   = f_gmul(a4,  a4);
        a16  = f_gmul(a8,  a8);
        a32  = f_gmul(a16, a16);
        a64  = f_gmul(a32, a32);
        a128 = f_gmul(a64, a64);
        // 2+4+8+16+32+64+128 = 254, so inv = a^-1 (and 0 maps to 0)
        inv  = f_gmul(f_gmul(f_gmul(a2, a4), f_gmul(a8, a16)),
                      f_gmul(f_gmul(a32, a64), a128));
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // One schedule word. There is a single SubWord per lane. Its input is
    // rotated only on the i mod Nk == 0 words.
    function automatic logic [31:0] f_lane(input logic [31:0] prev,
                                           input logic [31:0] back,
                                           input logic [3:0]  ph,
                                           input logic        nk8,
                                           input logic [7:0]  rcon);
        logic [31:0] sin;
        logic [31:0] sub;
        logic [31:0] temp;
        sin  = (ph == 4'd0) ? {prev[23:0], prev[31:24]} : prev;
        sub  = {f_sbox(sin[31:24]), f_sbox(sin[23:16]),
                f_sbox(sin[15:8]),  f_sbox(sin[7:0])};
        if (ph == 4'd0)
            temp = sub ^ {rcon, 24'h0};
        else if (nk8 && (ph == 4'd4))
            temp = sub;
        else
            temp = prev;
        return back ^ temp;
    endfunction

    // ------------------------------------------------------------------
    // State and storage
    // ------------------------------------------------------------------
    logic [0:0]   r_state;
    logic [0:0]   w_state_nxt;
    logic [31:0]  r_w [0:59];      // schedule file, intentionally not reset
    logic [5:0]   r_cnt;           // index of the next word to generate
    logic [3:0]   r_phase;         // r_cnt mod Nk, avoids a divider
    logic [7:0]   r_rcon;
    logic [3:0]   r_nk;
    logic [3:0]   r_nr;
    logic         r_done;
    logic         r_err;
    logic         r_rk_valid;
    logic [127:0] r_rd_key;

    logic         w_busy;
    logic         w_accept;
    logic         w_reject;
    logic         w_expand;
    logic         w_last;
    logic [3:0]   w_ld_nk;
    logic [3:0]   w_ld_nr;
    logic [5:0]   w_total;
    logic [6:0]   w_cnt_adv;
    logic [4:0]   w_phase_sum;
    logic [3:0]   w_phase_nxt;
    logic [7:0]   w_rcon_nxt;
    logic [5:0]   w_lane_idx  [0:c_WPC-1];
    logic [31:0]  w_lane_word [0:c_WPC-1];
    logic         w_lane_en   [0:c_WPC-1];
    logic         w_rd_ok;
    logic [5:0]   w_rd_base;

    assign w_ld_nk     = (bus.key_len == 2'd0) ? 4'd4  : (bus.key_len == 2'd1) ? 4'd6  : 4'd8;
    assign w_ld_nr     = (bus.key_len == 2'd0) ? 4'd10 : (bus.key_len == 2'd1) ? 4'd12 : 4'd14;
    assign w_total     = {r_nr + 4'd1, 2'b00};
    assign w_cnt_adv   = {1'b0, r_cnt} + 7'(c_WPC);
    assign w_phase_sum = {1'b0, r_phase} + 5'(c_WPC);
    assign w_phase_nxt = (w_phase_sum >= {1'b0, r_nk}) ? 4'(w_phase_sum - {1'b0, r_nk})
                                                       : w_phase_sum[3:0];

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:   if (w_accept) w_state_nxt = c_S_EXPAND;
            c_S_EXPAND: if (w_last)   w_state_nxt = c_S_IDLE;
            default:                  w_state_nxt = c_S_IDLE;
        endcase
    end

    always_comb begin
        w_busy   = (r_state == c_S_EXPAND);
        w_expand = (r_state == c_S_EXPAND);
        w_accept = (r_state == c_S_IDLE) && bus.start && (bus.key_len != 2'd3);
        w_reject = (r_state == c_S_IDLE) && bus.start && (bus.key_len == 2'd3);
        w_last   = w_expand && (w_cnt_adv >= {1'b0, w_total});
    end

    // ------------------------------------------------------------------
    // Lane chain. Lane j takes lane j-1's word as its w[i-1]. Because
    // Nk >= WORDS_PER_CYCLE, w[i-Nk] always lies in the already written
    // part of the file.
    // ------------------------------------------------------------------
    always_comb begin
        logic [31:0] w_prev;
        logic [7:0]  w_rc;
        logic [3:0]  w_ph;
        w_prev     = r_w[r_cnt - 6'd1];
        w_rc       = r_rcon;
        w_rcon_nxt = r_rcon;
        for (int j = 0; j < c_WPC; j++) begin
            w_ph = r_phase + 4'(j);
            if (w_ph >= r_nk) w_ph = w_ph - r_nk;
            w_lane_idx[j]  = r_cnt + 6'(j);
            w_lane_en[j]   = (w_lane_idx[j] < w_total);
            w_lane_word[j] = f_lane(w_prev, r_w[w_lane_idx[j] - {2'b00, r_nk}],
                                    w_ph, (r_nk == 4'd8), w_rc);
            if (w_ph == 4'd0) w_rc = f_xtime(w_rc);
            w_prev = w_lane_word[j];
        end
        w_rcon_nxt = w_rc;
    end

    // ------------------------------------------------------------------
    // Schedule file writes
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int k = 0; k < 8; k++) begin
                if (4'(k) < w_ld_nk) r_w[k] <= bus.key_in[255 - 32*k -: 32];
            end
        end else if (w_expand) begin
            for (int j = 0; j < c_WPC; j++) begin
                if (w_lane_en[j]) r_w[w_lane_idx[j]] <= w_lane_word[j];
            end
        end
    end

    // ------------------------------------------------------------------
    // Control registers and read port
    // ------------------------------------------------------------------
    // The read port is gated by rk_valid so that stale or partially built
    // schedules never leave the block.
    assign w_rd_ok   = r_rk_valid && (bus.rd_idx <= r_nr);
    assign w_rd_base = w_rd_ok ? {bus.rd_idx, 2'b00} : 6'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= 6'd0;
            r_phase    <= 4'd0;
            r_rcon     <= 8'h01;
            r_nk       <= 4'd0;
            r_nr       <= 4'd0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_rk_valid <= 1'b0;
            r_rd_key   <= 128'd0;
        end else begin
            r_done <= w_last;
            r_err  <= w_reject;
            if (w_accept) begin
                r_nk       <= w_ld_nk;
                r_nr       <= w_ld_nr;
                r_cnt      <= 6'(w_ld_nk);
                r_phase    <= 4'd0;
                r_rcon     <= 8'h01;
                r_rk_valid <= 1'b0;
            end else if (w_expand) begin
                r_cnt   <= w_cnt_adv[5:0];
                r_phase <= w_phase_nxt;
                r_rcon  <= w_rcon_nxt;
                if (w_last) r_rk_valid <= 1'b1;
            end
            r_rd_key <= w_rd_ok ? {r_w[w_rd_base],         r_w[w_rd_base + 6'd1],
                                   r_w[w_rd_base + 6'd2],  r_w[w_rd_base + 6'd3]}
                                : 128'd0;
        end
    end

    assign bus.busy       = w_busy;
    assign bus.done       = r_done;
    assign bus.rk_valid   = r_rk_valid;
    assign bus.num_rounds = r_nr;
    assign bus.err        = r_err;
    assign bus.rd_key     = r_rd_key;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_schedule_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_key_schedule_iter
//  Description : Directed self-checking bench for aes_key_schedule_iter.
//                There are three instances, with WORDS_PER_CYCLE = 1, 2 and 4.
//                They share clock and reset. Expected values are FIPS-197
//                reference vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_schedule_iter;

    localparam logic [255:0] c_KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hffffffffffffffffffffffffffffffff};
    localparam logic [255:0] c_KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hdeadbeefdeadbeef};
    localparam logic [255:0] c_KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] c_RK128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] c_RK192_12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] c_RK256 [0:14] = '{
        128'h603deb1015ca71be2b73aef0857d7781, 128'h1f352c073b6108d72d9810a30914dff4,
        128'h9ba354118e6925afa51a8b5f2067fcde, 128'ha8b09c1a93d194cdbe49846eb75d5b9a,
        128'hd59aecb85bf3c917fee94248de8ebe96, 128'hb5a9328a2678a647983122292f6c79b3,
        128'h812c81addadf48ba24360af2fab8b464, 128'h98c5bfc9bebd198e268c3ba709e04214,
        128'h68007bacb2df331696e939e46c518d80, 128'hc814e20476a9fb8a5025c02d59c58239,
        128'hde1369676ccc5a71fa2563959674ee15, 128'h5886ca5d2e2f31d77e0af1fa27cf73c3,
        128'h749c47ab18501ddae2757e4f7401905a, 128'hcafaaae3e4d59b349adf6acebd10190d,
        128'hfe4890d1e6188d0b046df344706c631e};

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    aes_key_schedule_iter_if if1 ();
    aes_key_schedule_iter_if if2 ();
    aes_key_schedule_iter_if if4 ();

    aes_key_schedule_iter #(.WORDS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    aes_key_schedule_iter #(.WORDS_PER_CYCLE(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    aes_key_schedule_iter #(.WORDS_PER_CYCLE(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         busy;
        logic         done;
        logic         rk_valid;
        logic         err;
        logic [3:0]   nr;
        logic [127:0] rk;
    } obs_t;

    function automatic obs_t obs(input int sel);
        obs_t o;
        case (sel)
            1:       o = {if1.busy, if1.done, if1.rk_valid, if1.err, if1.num_rounds, if1.rd_key};
            2:       o = {if2.busy, if2.done, if2.rk_valid, if2.err, if2.num_rounds, if2.rd_key};
            default: o = {if4.busy, if4.done, if4.rk_valid, if4.err, if4.num_rounds, if4.rd_key};
        endcase
        return o;
    endfunction

    task automatic drv(input int sel, input logic s, input logic [1:0] kl, input logic [255:0] k);
        case (sel)
            1:       begin if1.start = s; if1.key_len = kl; if1.key_in = k; end
            2:       begin if2.start = s; if2.key_len = kl; if2.key_in = k; end
            default: begin if4.start = s; if4.key_len = kl; if4.key_in = k; end
        endcase
    endtask

    task automatic set_idx(input int sel, input logic [3:0] idx);
        case (sel)
            1:       if1.rd_idx = idx;
            2:       if2.rd_idx = idx;
            default: if4.rd_idx = idx;
        endcase
    endtask

    // Every task starts and ends 1 time unit after a rising edge.
    task automatic read_rk(input int sel, input logic [3:0] idx, output logic [127:0] v);
        set_idx(sel, idx);
        @(posedge clk); #1;
        v = obs(sel).rk;
    endtask

    // Pulses start. On return the bench sits one step after the edge where
    // done is first seen. cycles is the edge count after the accepting
    // edge, or -1 if the wait timed out.
    task automatic run(input int sel, input logic [1:0] kl, input logic [255:0] key,
                       output int cycles, output logic busy0, output logic rkv0);
        drv(sel, 1'b1, kl, key);
        @(posedge clk); #1;
        drv(sel, 1'b0, 2'd0, 256'd0);
        busy0  = obs(sel).busy;
        rkv0   = obs(sel).rk_valid;
        cycles = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (obs(sel).done) begin cycles = c; break; end
        end
    endtask

    task automatic test_reset;
        obs_t o;
        o = obs(1);
        n_checks++; if (o.busy !== 1'b0)    $display("FAIL reset_busy: got %b expected 0", o.busy);         else n_pass++;
        n_checks++; if (o.done !== 1'b0)    $display("FAIL reset_done: got %b expected 0", o.done);         else n_pass++;
        n_checks++; if (o.rk_valid !== 1'b0) $display("FAIL reset_rk_valid: got %b expected 0", o.rk_valid); else n_pass++;
        n_checks++; if (o.err !== 1'b0)     $display("FAIL reset_err: got %b expected 0", o.err);           else n_pass++;
        n_checks++; if (o.nr !== 4'd0)      $display("FAIL reset_num_rounds: got %0d expected 0", o.nr);    else n_pass++;
        n_checks++; if (o.rk !== 128'd0)    $display("FAIL reset_rd_key: got %h expected 0", o.rk);         else n_pass++;
        n_checks++; if (obs(2) !== '0)      $display("FAIL reset_dut2: got %h expected 0", obs(2));         else n_pass++;
        n_checks++; if (obs(4) !== '0)      $display("FAIL reset_dut4: got %h expected 0", obs(4));         else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (obs(1).busy !== 1'b0 || obs(1).rk_valid !== 1'b0)
            $display("FAIL post_reset_idle: got busy=%b rk_valid=%b expected 0/0", obs(1).busy, obs(1).rk_valid);
        else n_pass++;
    endtask

    task automatic test_aes128;
        int cyc; logic b0, v0; logic [127:0] rk;
        run(1, 2'd0, c_KEY128, cyc, b0, v0);
        n_checks++; if (b0 !== 1'b1) $display("FAIL aes128_busy_at_start: got %b expected 1", b0); else n_pass++;
        n_checks++; if (cyc !== 40)  $display("FAIL aes128_latency: got %0d expected 40", cyc);   else n_pass++;
        n_checks++; if (obs(1).busy !== 1'b0 || obs(1).rk_valid !== 1'b1)
            $display("FAIL aes128_done_state: got busy=%b rk_valid=%b expected 0/1", obs(1).busy, obs(1).rk_valid);
        else n_pass++;
        n_checks++; if (obs(1).nr !== 4'd10) $display("FAIL aes128_num_rounds: got %0d expected 10", obs(1).nr); else n_pass++;
        read_rk(1, 4'd10, rk);
        n_checks++; if (obs(1).done !== 1'b0) $display("FAIL aes128_done_pulse: got %b expected 0", obs(1).done); else n_pass++;
        n_checks++; if (rk !== c_RK128_10) $display("FAIL aes128_rk10: got %h expected %h", rk, c_RK128_10); else n_pass++;
        read_rk(1, 4'd0, rk);
        n_checks++; if (rk !== c_KEY128[255:128]) $display("FAIL aes128_rk0: got %h expected %h", rk, c_KEY128[255:128]); else n_pass++;
    endtask

    task automatic test_aes192;
        int cyc; logic b0, v0; logic [127:0] rk;
        run(4, 2'd1, c_KEY192, cyc, b0, v0);
        n_checks++; if (cyc !== 12) $display("FAIL aes192_latency: got %0d expected 12", cyc); else n_pass++;
        n_checks++; if (obs(4).nr !== 4'd12) $display("FAIL aes192_num_rounds: got %0d expected 12", obs(4).nr); else n_pass++;
        read_rk(4, 4'd12, rk);
        n_checks++; if (rk !== c_RK192_12) $display("FAIL aes192_rk12: got %h expected %h", rk, c_RK192_12); else n_pass++;
    endtask

    // Full AES-256 schedule on one instance. The reads run back to back,
    // one index per cycle.
    task automatic test_aes256(input int sel, input int exp_cyc);
        int cyc; logic b0, v0; logic [127:0] rk;
        run(sel, 2'd2, c_KEY256, cyc, b0, v0);
        n_checks++; if (cyc !== exp_cyc) $display("FAIL aes256_latency_wpc%0d: got %0d expected %0d", sel, cyc, exp_cyc); else n_pass++;
        n_checks++; if (obs(sel).nr !== 4'd14) $display("FAIL aes256_num_rounds_wpc%0d: got %0d expected 14", sel, obs(sel).nr); else n_pass++;
        set_idx(sel, 4'd0);
        for (int r = 1; r <= 15; r++) begin
            @(posedge clk); #1;
            rk = obs(sel).rk;
            if (r <= 14) set_idx(sel, 4'(r));
            n_checks++;
            if (rk !== c_RK256[r-1]) $display("FAIL aes256_rk%0d_wpc%0d: got %h expected %h", r-1, sel, rk, c_RK256[r-1]);
            else n_pass++;
        end
    endtask

    task automatic test_ignored_start;
        int cyc; logic [127:0] rk;
        drv(2, 1'b1, 2'd2, c_KEY256);
        @(posedge clk); #1;
        drv(2, 1'b0, 2'd0, 256'd0);
        cyc = -1;
        for (int c = 1; c <= 200; c++) begin
            if (c == 5) drv(2, 1'b1, 2'd0, c_KEY128);
            if (c == 6) drv(2, 1'b0, 2'd0, 256'd0);
            @(posedge clk); #1;
            if (obs(2).done) begin cyc = c; break; end
        end
        n_checks++; if (cyc !== 26) $display("FAIL midstart_latency: got %0d expected 26", cyc); else n_pass++;
        n_checks++; if (obs(2).nr !== 4'd14) $display("FAIL midstart_num_rounds: got %0d expected 14", obs(2).nr); else n_pass++;
        read_rk(2, 4'd14, rk);
        n_checks++; if (rk !== c_RK256[14]) $display("FAIL midstart_rk14: got %h expected %h", rk, c_RK256[14]); else n_pass++;
        // reserved key length in IDLE
        drv(2, 1'b1, 2'd3, c_KEY128);
        @(posedge clk); #1;
        drv(2, 1'b0, 2'd0, 256'd0);
        n_checks++; if (obs(2).err !== 1'b1) $display("FAIL badlen_err: got %b expected 1", obs(2).err); else n_pass++;
        n_checks++; if (obs(2).busy !== 1'b0) $display("FAIL badlen_busy: got %b expected 0", obs(2).busy); else n_pass++;
        n_checks++; if (obs(2).rk_valid !== 1'b1) $display("FAIL badlen_rk_valid: got %b expected 1", obs(2).rk_valid); else n_pass++;
        n_checks++; if (obs(2).nr !== 4'd14) $display("FAIL badlen_num_rounds: got %0d expected 14", obs(2).nr); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (obs(2).err !== 1'b0 || obs(2).busy !== 1'b0)
            $display("FAIL badlen_pulse: got err=%b busy=%b expected 0/0", obs(2).err, obs(2).busy);
        else n_pass++;
        read_rk(2, 4'd14, rk);
        n_checks++; if (rk !== c_RK256[14]) $display("FAIL badlen_rk14: got %h expected %h", rk, c_RK256[14]); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int cyc; logic b0, v0; logic [127:0] rk;
        set_idx(1, 4'd0);
        drv(1, 1'b1, 2'd2, c_KEY256);
        @(posedge clk); #1;
        drv(1, 1'b0, 2'd0, 256'd0);
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        n_checks++; if (obs(1).busy !== 1'b0 || obs(1).rk_valid !== 1'b0 || obs(1).rk !== 128'd0)
            $display("FAIL midreset_clear: got busy=%b rk_valid=%b rd_key=%h expected 0/0/0", obs(1).busy, obs(1).rk_valid, obs(1).rk);
        else n_pass++;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run(1, 2'd0, c_KEY128, cyc, b0, v0);
        n_checks++; if (cyc !== 40) $display("FAIL midreset_rerun_latency: got %0d expected 40", cyc); else n_pass++;
        read_rk(1, 4'd10, rk);
        n_checks++; if (rk !== c_RK128_10) $display("FAIL midreset_rerun_rk10: got %h expected %h", rk, c_RK128_10); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int cyc; logic b0, v0; logic [127:0] rk;
        run(4, 2'd2, c_KEY256, cyc, b0, v0);
        n_checks++; if (cyc !== 13) $display("FAIL b2b_aes256_latency: got %0d expected 13", cyc); else n_pass++;
        // start while done is still high
        run(4, 2'd0, c_KEY128, cyc, b0, v0);
        n_checks++; if (b0 !== 1'b1 || v0 !== 1'b0)
            $display("FAIL b2b_start_accept: got busy=%b rk_valid=%b expected 1/0", b0, v0);
        else n_pass++;
        n_checks++; if (cyc !== 10) $display("FAIL b2b_aes128_latency: got %0d expected 10", cyc); else n_pass++;
        n_checks++; if (obs(4).nr !== 4'd10) $display("FAIL b2b_num_rounds: got %0d expected 10", obs(4).nr); else n_pass++;
        read_rk(4, 4'd11, rk);
        n_checks++; if (rk !== 128'd0) $display("FAIL b2b_rk11_zero: got %h expected 0", rk); else n_pass++;
        read_rk(4, 4'd10, rk);
        n_checks++; if (rk !== c_RK128_10) $display("FAIL b2b_rk10: got %h expected %h", rk, c_RK128_10); else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        drv(1, 1'b0, 2'd0, 256'd0); set_idx(1, 4'd0);
        drv(2, 1'b0, 2'd0, 256'd0); set_idx(2, 4'd0);
        drv(4, 1'b0, 2'd0, 256'd0); set_idx(4, 4'd0);
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        test_aes128;
        test_aes192;
        test_aes256(1, 52);
        test_aes256(2, 26);
        test_aes256(4, 13);
        test_ignored_start;
        test_reset_mid;
        test_back_to_back;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_key_schedule_iter.md
# aes_key_schedule_iter

Iterative, parametrised AES key-expansion engine that supports AES-128, AES-192 and AES-256 from one instance, selected per run. It replaces the fixed AES-256 combinational/pipelined expander with a sequential generator. The generator produces WORDS_PER_CYCLE schedule words per clock into an internal 60-word file. The round-key read port serves the cipher datapath; a start/busy/done handshake sequences key loads.

## Interface
- WORDS_PER_CYCLE, 1: schedule words computed per cycle; legal values are 1, 2 and 4. Each lane instantiates 4 sbox.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a new expansion; sampled only when busy=0
- key_len  in  2  0=AES-128, 1=AES-192, 2=AES-256, 3=reserved; sampled with start
- key_in  in  256  cipher key, MSB-aligned; 128-bit key in [255:128], 192-bit key in [255:64], unused LSBs ignored
- busy  out  1  expansion in progress
- done  out  1  one-cycle pulse when the last word is written
- rk_valid  out  1  level; the word file holds a complete schedule for the latched key
- num_rounds  out  4  Nr of the latched config: 10, 12 or 14
- err  out  1  one-cycle pulse when start is sampled with key_len=3
- rd_idx  in  4  round-key index 0..Nr
- rd_key  out  128  registered {w[4r],w[4r+1],w[4r+2],w[4r+3]}

## Operation
- Nk is 4, 6 or 8 and Nr is 10, 12 or 14, both derived from key_len. Total words T=4*(Nr+1): 44, 52 or 60.
- States:
  - IDLE→EXPAND on start with key_len≠3.
  - start with key_len=3 pulses err, stays IDLE and changes nothing else.
- Accepted start:
  - Latch Nk and Nr; write key words w[0..Nk-1] from key_in (w[0]=key_in[255:224]).
  - Set cnt=Nk, rcon=8'h01; clear rk_valid.
- EXPAND, each cycle, lane j=0..WPC-1 computes index i=cnt+j:
  - temp is w[i-1]; lane j>0 uses lane j-1's result combinationally.
  - i mod Nk==0: temp=SubWord(RotWord(temp))^{rcon,24'h0}. rcon advances by xtime (shift left 1, XOR 8'h1b when bit 7 set) once per such word.
  - Nk==8 and i mod 8==4: temp=SubWord(temp).
  - Otherwise temp is unchanged.
  - w[i]=w[i-Nk]^temp. w[i-Nk] is read from the file or from an earlier lane in the same cycle.
  - Lanes with i≥T are suppressed and do not write.
  - cnt+=WPC.
- Transitions from EXPAND:
  - After the write with cnt+WPC≥T: next state IDLE, done=1, rk_valid=1.
  - start in EXPAND is ignored.
- rd_key:
  - rd_key<=file contents for rd_idx every cycle, independent of state.
  - rd_idx>Nr gives rd_key<=0.
  - When rk_valid=0 the content of rd_key is not guaranteed.
- The word file is not cleared by reset; stale words are never exposed as valid.

## Timing
- Reset values: busy=0, done=0, rk_valid=0, err=0, num_rounds=0, rd_key=0, state=IDLE. Reset mid-expansion aborts and returns to IDLE within the reset assertion.
- start sampled at edge E0 loads the key. busy=1 from E0 until the final edge EN, with N=ceil((T-Nk)/WPC):
  - WPC=1: 40, 46, 52 cycles.
  - WPC=2: 20, 23, 26 cycles.
  - WPC=4: 10, 12, 13 cycles.
- At EN: busy falls, done pulses for one cycle, rk_valid rises.
- A start asserted in the cycle after done is accepted.
- rd_key latency is 1 cycle from rd_idx; back-to-back reads are allowed every cycle.
- rk_valid stays high until the next accepted start or reset.

## Test plan
- AES-128, FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, WPC=1 → done 40 cycles after start. rd_idx=10 → d014f9a8c9ee2589e13f0cc8b6630ca6. rd_idx=0 → key.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, WPC=4 → done after 12 cycles; num_rounds=12. rd_idx=12 → e98ba06f448c773c8ecc720401002202.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, WPC∈{1,2,4} → rd_idx=14 → fe4890d1e6188d0b046df344706c631e. Check all 15 round keys against the software model.
- start pulsed mid-expansion and key_len=3 in IDLE: start is ignored with identical results; key_len=3 gives an err pulse, busy stays 0 and rk_valid is unchanged.
- rst_n asserted at cycle 5 of an expansion → busy, rk_valid and rd_key go to 0 immediately. A new AES-128 run then completes correctly.
- After an AES-256 run, start an AES-128 run → rk_valid drops at start. At done, rd_idx=11 → 0 and num_rounds=10.
